// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: request record,
// FSM state and owner encodings.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arbstate_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic req_t take_req(input logic [ADDR_W-1:0] addr,
                                      input logic              wen,
                                      input logic [DATA_W-1:0] wdata);
        req_t r;
        r.addr  = addr;
        r.wen   = wen;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CacheReq / CacheResp bundles. master drives the transfer, slave answers
// (ready on requests); on responses the master is the side producing data.
interface cache_req_if;
    import mem_port_arbiter_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;

    modport master (output valid, output addr, output wen, output wdata, input ready);
    modport slave  (input valid, input addr, input wen, input wdata, output ready);
endinterface

interface cache_resp_if;
    import mem_port_arbiter_pkg::*;

    logic              valid;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, output rdata);
    modport slave  (input valid, input rdata);
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the i and d requesters.
// Build with MEMARB_ROUND_ROBIN_EN for alternating grants; otherwise DPRIORITY rules.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter bit DPRIORITY = 1'b1
) (
    input  logic   ivalid,
    input  logic   dvalid,
    input  owner_t last_grant,
    output owner_t sel,
    output logic   any
);

    owner_t both_win;

`ifdef MEMARB_ROUND_ROBIN_EN
    localparam bit unused_dpriority = DPRIORITY;
    assign both_win = (last_grant == OWN_I) ? OWN_D : OWN_I;
`else
    // last_grant is tracked by the top in every build but only consumed here under round-robin
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == OWN_D);
    assign both_win = DPRIORITY ? OWN_D : OWN_I;
`endif

    always_comb begin
        sel = OWN_I;
        any = ivalid | dvalid;
        if (ivalid && dvalid) sel = both_win;
        else if (dvalid)      sel = OWN_D;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one CacheReq/CacheResp port between the
// instruction and data sides. Optional MEMARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit DPRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_req_if.slave   ireq,
    cache_resp_if.master iresp,
    cache_req_if.slave   dreq,
    cache_resp_if.master dresp,
    cache_req_if.master  memreq,
    cache_resp_if.slave  memresp,
    input  logic         ikill,
    input  logic         dkill
);

    arbstate_t state;
    owner_t    owner;
    owner_t    last_grant;
    logic      drop;
    req_t      s_req;

    owner_t    sel;
    logic      any;
    logic      ivld;
    logic      dvld;
    logic      idle;
    logic      accept;
    logic      kill_owner;
    logic      resp_ok;
    req_t      in_req;

    // A killed side is invisible to selection
    assign ivld = ireq.valid & ~ikill;
    assign dvld = dreq.valid & ~dkill;

    mem_arb_pick #(.DPRIORITY(DPRIORITY)) u_pick (
        .ivalid     (ivld),
        .dvalid     (dvld),
        .last_grant (last_grant),
        .sel        (sel),
        .any        (any)
    );

    assign idle       = rst_n && (state == IDLE);
    assign accept     = idle && any;
    assign ireq.ready = accept && (sel == OWN_I);
    assign dreq.ready = accept && (sel == OWN_D);

    assign in_req = (sel == OWN_D) ? take_req(dreq.addr, dreq.wen, dreq.wdata)
                                   : take_req(ireq.addr, ireq.wen, ireq.wdata);

    assign kill_owner = (owner == OWN_D) ? dkill : ikill;

    assign memreq.valid = rst_n && (state == ISSUE);
    assign memreq.addr  = s_req.addr;
    assign memreq.wen   = s_req.wen;
    assign memreq.wdata = s_req.wdata;

    // A kill landing on the response cycle suppresses it directly, before drop could register
    assign resp_ok     = rst_n && (state == WAIT) && memresp.valid && !drop && !kill_owner;
    assign iresp.valid = resp_ok && (owner == OWN_I);
    assign dresp.valid = resp_ok && (owner == OWN_D);
    assign iresp.rdata = memresp.rdata;
    assign dresp.rdata = memresp.rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            drop       <= 1'b0;
            s_req      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_req <= in_req;
                        owner <= sel;
                        drop  <= 1'b0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Once memory has taken the request a response is owed, so a kill only drops it
                    if (memreq.ready) begin
                        drop  <= kill_owner;
                        state <= WAIT;
                    end else if (kill_owner) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (memresp.valid) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end else if (kill_owner) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized transaction bench for mem_port_arbiter against a
// transaction-level model of grant choice and response delivery.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam bit DPRI = 1'b1;

    logic clk = 1'b0;
    logic rst_n;
    logic ikill;
    logic dkill;
    int   checks = 0;
    int   failures = 0;
    owner_t m_last;

    cache_req_if  ireq_if ();
    cache_resp_if iresp_if ();
    cache_req_if  dreq_if ();
    cache_resp_if dresp_if ();
    cache_req_if  memreq_if ();
    cache_resp_if memresp_if ();

    mem_port_arbiter #(.DPRIORITY(DPRI)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ireq    (ireq_if),
        .iresp   (iresp_if),
        .dreq    (dreq_if),
        .dresp   (dresp_if),
        .memreq  (memreq_if),
        .memresp (memresp_if),
        .ikill   (ikill),
        .dkill   (dkill)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winner from the arbitration rule; a lone request always wins
    function automatic owner_t ref_pick(input bit iv, input bit dv);
        if (iv && !dv) return OWN_I;
        if (dv && !iv) return OWN_D;
`ifdef MEMARB_ROUND_ROBIN_EN
        return (m_last == OWN_I) ? OWN_D : OWN_I;
`else
        return DPRI ? OWN_D : OWN_I;
`endif
    endfunction

    task automatic set_kill(input owner_t who, input bit v);
        if (who == OWN_I) ikill = v;
        else              dkill = v;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_iready"}, ireq_if.ready, 0);
        chk({tag, "_dready"}, dreq_if.ready, 0);
        chk({tag, "_iresp"}, iresp_if.valid, 0);
        chk({tag, "_dresp"}, dresp_if.valid, 0);
    endtask

    // kmode: 0 none, 1 owner kill in ISSUE, 2 owner kill first WAIT cycle,
    // 3 owner kill on response cycle, 4 non-owner kill in WAIT, 5 owner kill with memreq.ready
    task automatic txn(input bit iv, input bit dv, input bit mi, input bit md,
                       input logic [31:0] ia, input logic [31:0] da,
                       input bit iw, input bit dw,
                       input logic [31:0] iwd, input logic [31:0] dwd,
                       input int stall, input int lat_in, input int kmode,
                       input logic [31:0] rd);
        owner_t w, o;
        logic [31:0] ea, ed;
        bit ew, deliver;
        int lat;
        lat = (kmode == 2 && lat_in < 2) ? 2 : lat_in;
        w = ref_pick(iv && !mi, dv && !md);
        o = (w == OWN_I) ? OWN_D : OWN_I;
        ea = (w == OWN_I) ? ia : da;
        ed = (w == OWN_I) ? iwd : dwd;
        ew = (w == OWN_I) ? iw : dw;
        deliver = (kmode == 0) || (kmode == 4);

        ireq_if.addr = ia; ireq_if.wen = iw; ireq_if.wdata = iwd;
        dreq_if.addr = da; dreq_if.wen = dw; dreq_if.wdata = dwd;
        ireq_if.valid = iv; dreq_if.valid = dv;
        ikill = mi; dkill = md;
        settle();
        chk("idle_iready", ireq_if.ready, w == OWN_I);
        chk("idle_dready", dreq_if.ready, w == OWN_D);
        chk("idle_memvalid", memreq_if.valid, 0);
        step();
        ikill = 1'b0; dkill = 1'b0;

        for (int s = 0; s < stall; s++) begin
            memreq_if.ready = 1'b0;
            settle();
            chk("iss_memvalid", memreq_if.valid, 1);
            chk("iss_addr", memreq_if.addr, ea);
            chk_quiet("iss");
            step();
        end

        if (kmode == 1) begin
            set_kill(w, 1'b1);
            memreq_if.ready = 1'b0;
            settle();
            chk("kiss_memvalid", memreq_if.valid, 1);
            step();
            set_kill(w, 1'b0);
            ireq_if.valid = 1'b0; dreq_if.valid = 1'b0;
            settle();
            chk("kiss_back_memvalid", memreq_if.valid, 0);
            chk_quiet("kiss_back");
            step();
            return;
        end

        memreq_if.ready = 1'b1;
        if (kmode == 5) set_kill(w, 1'b1);
        settle();
        chk("iss_memvalid", memreq_if.valid, 1);
        chk("iss_addr", memreq_if.addr, ea);
        chk("iss_wen", memreq_if.wen, ew);
        chk("iss_wdata", memreq_if.wdata, ed);
        chk_quiet("iss");
        step();
        memreq_if.ready = 1'b0;
        set_kill(w, 1'b0);

        for (int k = 1; k < lat; k++) begin
            if (kmode == 2 && k == 1) set_kill(w, 1'b1);
            if (kmode == 4) set_kill(o, 1'b1);
            memresp_if.rdata = $urandom;
            settle();
            chk("wait_memvalid", memreq_if.valid, 0);
            chk("wait_rdata_mirror", iresp_if.rdata, memresp_if.rdata);
            chk_quiet("wait");
            step();
            ikill = 1'b0; dkill = 1'b0;
        end

        memresp_if.valid = 1'b1;
        memresp_if.rdata = rd;
        if (kmode == 3) set_kill(w, 1'b1);
        if (kmode == 4) set_kill(o, 1'b1);
        settle();
        chk("resp_ivalid", iresp_if.valid, deliver && (w == OWN_I));
        chk("resp_dvalid", dresp_if.valid, deliver && (w == OWN_D));
        chk("resp_irdata", iresp_if.rdata, rd);
        chk("resp_drdata", dresp_if.rdata, rd);
        chk("resp_iready", ireq_if.ready, 0);
        chk("resp_dready", dreq_if.ready, 0);
        step();
        m_last = w;
        memresp_if.valid = 1'b0;
        ikill = 1'b0; dkill = 1'b0;
        ireq_if.valid = 1'b0; dreq_if.valid = 1'b0;
        settle();
        chk("post_memvalid", memreq_if.valid, 0);
        chk_quiet("post");
        step();
    endtask

    initial begin
        m_last = OWN_I;
        rst_n = 1'b0;
        ikill = 1'b0; dkill = 1'b0;
        ireq_if.valid = 1'b1; ireq_if.addr = '0; ireq_if.wen = 1'b0; ireq_if.wdata = '0;
        dreq_if.valid = 1'b1; dreq_if.addr = '0; dreq_if.wen = 1'b0; dreq_if.wdata = '0;
        memreq_if.ready = 1'b1;
        memresp_if.valid = 1'b1; memresp_if.rdata = 32'h5555_AAAA;
        step(); step();
        settle();
        chk("rst_memvalid", memreq_if.valid, 0);
        chk_quiet("rst");
        step();
        rst_n = 1'b1;
        ireq_if.valid = 1'b0; dreq_if.valid = 1'b0;
        memreq_if.ready = 1'b0; memresp_if.valid = 1'b0;
        settle();
        chk_quiet("rst_idle");
        step();

        // Single read
        txn(0, 1, 0, 0, 32'h0, 32'h8000_0010, 0, 0, 32'h0, 32'h0, 0, 3, 0, 32'hDEAD_BEEF);
        // Contention
        for (int n = 0; n < 4; n++)
            txn(1, 1, 0, 0, 32'h1000 + n, 32'h2000 + n, 0, 0, 32'h0, 32'h0, 0, 1, 0, $urandom);
        // Kill masks a side in IDLE
        txn(1, 1, 0, 1, 32'h3000, 32'h3004, 0, 0, 32'h0, 32'h0, 0, 1, 0, $urandom);
        txn(1, 1, 1, 0, 32'h3008, 32'h300C, 0, 0, 32'h0, 32'h0, 0, 1, 0, $urandom);
        // Kill in ISSUE, then a d request
        txn(1, 0, 0, 0, 32'h4000, 32'h0, 0, 0, 32'h0, 32'h0, 1, 2, 1, $urandom);
        txn(0, 1, 0, 0, 32'h0, 32'h4004, 0, 0, 32'h0, 32'h0, 0, 2, 0, $urandom);
        // Kill in WAIT, then a normal i request
        txn(1, 0, 0, 0, 32'h5000, 32'h0, 0, 0, 32'h0, 32'h0, 0, 3, 2, $urandom);
        txn(1, 0, 0, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2, 0, 32'hCAFE_0100);
        // Write passthrough
        txn(0, 1, 0, 0, 32'h0, 32'h40, 0, 1, 32'h0, 32'h1234_5678, 0, 2, 0, $urandom);
        // Kill on response cycle, non-owner kill, kill together with ready
        txn(0, 1, 0, 0, 32'h0, 32'h6000, 0, 0, 32'h0, 32'h0, 0, 2, 3, $urandom);
        txn(1, 1, 0, 0, 32'h6004, 32'h6008, 0, 0, 32'h0, 32'h0, 0, 3, 4, $urandom);
        txn(1, 0, 0, 0, 32'h600C, 32'h0, 0, 0, 32'h0, 32'h0, 1, 2, 5, $urandom);

        // Reset while in WAIT; a late response must not leak out
        dreq_if.valid = 1'b1; dreq_if.addr = 32'h200;
        settle();
        chk("mrst_dready", dreq_if.ready, 1);
        step();
        dreq_if.valid = 1'b0;
        memreq_if.ready = 1'b1;
        settle();
        chk("mrst_memvalid_iss", memreq_if.valid, 1);
        step();
        memreq_if.ready = 1'b0;
        rst_n = 1'b0;
        ireq_if.valid = 1'b1; dreq_if.valid = 1'b1;
        memresp_if.valid = 1'b1;
        settle();
        chk("mrst_memvalid", memreq_if.valid, 0);
        chk_quiet("mrst");
        step();
        rst_n = 1'b1;
        m_last = OWN_I;
        ireq_if.valid = 1'b0; dreq_if.valid = 1'b0;
        settle();
        chk("late_memvalid", memreq_if.valid, 0);
        chk_quiet("late");
        step();
        memresp_if.valid = 1'b0;
        step();

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            bit iv, dv, mi, md;
            int r;
            r = $urandom_range(0, 2);
            iv = (r != 1);
            dv = (r != 0);
            r = $urandom_range(0, 5);
            mi = (r == 0) && iv && dv;
            md = (r == 1) && iv && dv;
            txn(iv, dv, mi, md, $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 5), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
